// File: rtl/int_ret_ctrl.sv
// Interrupt/return sequencer: arbitrates int_req, redirects the PC to a vector and
// replays saved return addresses. Define INT_NESTING_EN for priority-based preemption.
module int_ret_ctrl #(
  parameter int                        ADDR_WIDTH_MEM = 16,
  parameter int                        DDR_ADDR_WIDTH = 28,
  parameter int                        NUM_INT        = 4,
  parameter int                        STACK_DEPTH    = 4,
  parameter logic [DDR_ADDR_WIDTH-1:0] VEC_BASE       = 'h0000400,
  parameter int                        VEC_STRIDE     = 64
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_INT-1:0]        int_req,
  output logic [NUM_INT-1:0]        int_ack,
  input  logic                      ins_inp_valid,
  input  logic                      ret_ins,
  input  logic [ADDR_WIDTH_MEM-1:0] addr_cur_ins,
  output logic                      int_o,
  output logic [DDR_ADDR_WIDTH-1:0] jmp_addr_pc,
  output logic                      ret_valid,
  output logic [ADDR_WIDTH_MEM-1:0] ret_addr_pc,
  output logic                      ret_addr_pc_rdy,
  output logic                      stack_empty,
  output logic                      stack_full,
  output logic                      ret_err
);
`ifdef INT_NESTING_EN
  localparam int DEPTH = STACK_DEPTH;
`else
  localparam int DEPTH = (STACK_DEPTH >= 1) ? 1 : 0;
`endif
  localparam int SPW = $clog2(DEPTH + 1);
  localparam int LW  = (NUM_INT > 1) ? $clog2(NUM_INT) : 1;

  typedef enum logic [2:0] {IDLE, PUSH, JUMP, WAIT_JMP, POP, RET_WAIT} state_e;

  state_e                    state_q;
  logic [SPW-1:0]            sp_q;
  logic [LW-1:0]             idx_q;
  logic [NUM_INT-1:0]        ack_q;
  logic                      int_q, ret_valid_q, rdy_q, empty_q, full_q, err_q, ret_pend_q;
  logic [DDR_ADDR_WIDTH-1:0] jmp_q;
  logic [ADDR_WIDTH_MEM-1:0] ret_addr_q;

  logic [LW-1:0]             req_idx;
  logic                      req_any, eligible;
  logic [ADDR_WIDTH_MEM-1:0] top_addr;
  logic [DDR_ADDR_WIDTH-1:0] vec_addr;

  always_comb begin
    req_idx = '0;
    req_any = 1'b0;
    for (int i = NUM_INT - 1; i >= 0; i--) begin
      if (int_req[i]) begin
        req_idx = LW'(i);
        req_any = 1'b1;
      end
    end
  end

`ifdef INT_NESTING_EN
  localparam int IW = $clog2(STACK_DEPTH);
  logic [ADDR_WIDTH_MEM-1:0] stk_addr_q [STACK_DEPTH];
  logic [LW-1:0]             stk_lvl_q  [STACK_DEPTH];
  logic [IW-1:0]             top_idx;

  assign top_idx  = IW'(sp_q - 1'b1);
  assign top_addr = stk_addr_q[top_idx];
  // The active level is the top entry's level, so a pop restores the one below.
  assign eligible = req_any && ((sp_q == '0) || (req_idx < stk_lvl_q[top_idx]));

  always_ff @(posedge clk) begin
    if (state_q == PUSH) begin
      stk_addr_q[sp_q[IW-1:0]] <= addr_cur_ins;
      stk_lvl_q[sp_q[IW-1:0]]  <= idx_q;
    end
  end
`else
  logic [ADDR_WIDTH_MEM-1:0] stk_addr_q;

  assign top_addr = stk_addr_q;
  assign eligible = req_any && (sp_q == '0);

  always_ff @(posedge clk) begin
    if (state_q == PUSH) stk_addr_q <= addr_cur_ins;
  end
`endif

  assign vec_addr = VEC_BASE + DDR_ADDR_WIDTH'(idx_q) * DDR_ADDR_WIDTH'(VEC_STRIDE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      sp_q        <= '0;
      idx_q       <= '0;
      ack_q       <= '0;
      int_q       <= 1'b0;
      jmp_q       <= '0;
      ret_valid_q <= 1'b0;
      ret_addr_q  <= '0;
      rdy_q       <= 1'b0;
      empty_q     <= 1'b1;
      full_q      <= 1'b0;
      err_q       <= 1'b0;
      ret_pend_q  <= 1'b0;
    end else begin
      ack_q <= '0;
      int_q <= 1'b0;
      if (ret_ins && state_q != IDLE) ret_pend_q <= 1'b1;
      case (state_q)
        IDLE: begin
          if (ret_ins || ret_pend_q) begin
            ret_pend_q <= 1'b0;
            state_q    <= POP;
          end else if (ins_inp_valid && eligible && !full_q) begin
            idx_q   <= req_idx;
            ack_q   <= NUM_INT'(1) << req_idx;
            state_q <= PUSH;
          end
        end
        PUSH: begin
          sp_q    <= sp_q + 1'b1;
          empty_q <= 1'b0;
          full_q  <= (sp_q == SPW'(DEPTH - 1));
          jmp_q   <= vec_addr;
          int_q   <= 1'b1;
          state_q <= JUMP;
        end
        JUMP: state_q <= WAIT_JMP;
        WAIT_JMP: if (ins_inp_valid) state_q <= IDLE;
        POP: begin
          if (!empty_q) begin
            sp_q        <= sp_q - 1'b1;
            empty_q     <= (sp_q == SPW'(1));
            full_q      <= 1'b0;
            ret_addr_q  <= top_addr;
            ret_valid_q <= 1'b1;
            state_q     <= RET_WAIT;
          end else begin
            err_q   <= 1'b1;
            state_q <= IDLE;
          end
        end
        RET_WAIT: begin
          if (ins_inp_valid) begin
            ret_valid_q <= 1'b0;
            rdy_q       <= 1'b0;
            state_q     <= IDLE;
          end else begin
            rdy_q <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign int_ack         = ack_q;
  assign int_o           = int_q;
  assign jmp_addr_pc     = jmp_q;
  assign ret_valid       = ret_valid_q;
  assign ret_addr_pc     = ret_addr_q;
  assign ret_addr_pc_rdy = rdy_q;
  assign stack_empty     = empty_q;
  assign stack_full      = full_q;
  assign ret_err         = err_q;
endmodule
